// File: rtl/pixel_frame_writer_if.sv
// Pixel stream handshake: a beat transfers on valid & ready.
interface dstream #(
  parameter int W = 30
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport in  (input data, input valid, output ready);
  modport out (output data, output valid, input ready);
endinterface

// File: rtl/pixel_frame_writer.sv
// Frame-buffer sink: buffers the pixel stream in a 2-entry FIFO and writes it
// in raster order to a RAM write port, tracking col/row and completed frames.
module pixel_frame_writer #(
  parameter int W      = 30,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic                      clk,
  input  logic                      reset,
  dstream.in                        x,
  input  logic                      enable,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [W-1:0]              wr_data,
  input  logic                      wr_ready,
  output logic                      frame_done,
  output logic [15:0]               frame_count,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [1:0]   fill;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [W-1:0] fifo_q [2];

  logic push;
  logic load;
  logic accept;
  logic last;

  // Upstream ready depends on registers only, so stalls never ripple combinationally.
  assign x.ready = (state == RUN) && (fill != 2'd2);
  assign push    = x.valid && x.ready;
  assign load    = (!wr_en || wr_ready) && (fill != 2'd0);
  assign accept  = wr_en && wr_ready;
  assign last    = accept && (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= x.data;
  end

  // FSM and FIFO bookkeeping; enable only matters in IDLE or on the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      fill   <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (last && !enable) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= ~wr_ptr;
      if (load) rd_ptr <= ~rd_ptr;
      case ({push, load})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  // Output stage and raster position; the address tracks row*WIDTH+col incrementally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_data     <= '0;
      wr_addr     <= '0;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (load) begin
        wr_en   <= 1'b1;
        wr_data <= fifo_q[rd_ptr];
      end else if (wr_ready) begin
        wr_en <= 1'b0;
      end
      frame_done <= last;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row         <= '0;
            wr_addr     <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            row     <= row + RW'(1);
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end else begin
          col     <= col + CW'(1);
          wr_addr <= wr_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
